// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with a one-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
`default_nettype none

module pipe_stage_buf #(
   parameter int unsigned          WIDTH     = 32,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0,
   parameter int unsigned          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             in_fire;
   logic             out_fire;

   // Both handshake outputs derive only from the state register.
   assign out_valid = (state_q != S_EMPTY);
   assign in_ready  = (state_q != S_TWO);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign stall_cnt = stall_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      stall_d = stall_q;

      if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + 1'b1;

      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = S_ONE;
               end
            end
            S_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  skid_d  = in_data;
                  state_d = S_TWO;
               end else if (out_fire) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: a 32-bit instance for the
// handshake scenarios and a CNT_W=4 instance for counter saturation.
`default_nettype none

module tb_pipe_stage_buf;

   localparam logic [31:0] RV = 32'h5A5A_0001;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, flush;
   logic        in_ready, out_valid;
   logic [31:0] in_data, out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   logic        s_rst, s_in_valid, s_out_ready, s_flush;
   logic        s_in_ready, s_out_valid;
   logic [7:0]  s_in_data, s_out_data;
   logic [1:0]  s_occupancy;
   logic [3:0]  s_stall_cnt;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.WIDTH(32), .RESET_VAL(RV), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .flush(flush), .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_buf #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_data(s_out_data), .flush(s_flush), .occupancy(s_occupancy),
      .stall_cnt(s_stall_cnt)
   );

   // Inputs change 1ns after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0; flush = 1'b0;
      tick(); tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
      n_total++; if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d exp 0", occupancy); else n_pass++;
      n_total++; if (out_data !== RV) $display("FAIL reset_out_data got %h exp %h", out_data, RV); else n_pass++;
      n_total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall got %0d exp 0", stall_cnt); else n_pass++;
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = 32'(i);
         n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); else n_pass++;
         tick();
         n_total++; if (out_valid !== 1'b1 || out_data !== 32'(i))
            $display("FAIL stream_out[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 32'(i));
         else n_pass++;
      end
      in_valid = 1'b0;
      tick();
      n_total++; if (occupancy !== 2'd0) $display("FAIL stream_drain_occ got %0d exp 0", occupancy); else n_pass++;
      n_total++; if (stall_cnt !== 16'd0) $display("FAIL stream_stall got %0d exp 0", stall_cnt); else n_pass++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; tick();
      in_data = 32'hB; tick();
      in_data = 32'hC; tick();
      n_total++; if (occupancy !== 2'd2) $display("FAIL bp_occ got %0d exp 2", occupancy); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", in_ready); else n_pass++;
      n_total++; if (out_data !== 32'hA) $display("FAIL bp_head got %h exp a", out_data); else n_pass++;
      n_total++; if (stall_cnt !== 16'd2) $display("FAIL bp_stall got %0d exp 2", stall_cnt); else n_pass++;
      out_ready = 1'b1; tick();
      n_total++; if (out_data !== 32'hB || occupancy !== 2'd1)
         $display("FAIL bp_second got d=%h occ=%0d exp d=b occ=1", out_data, occupancy); else n_pass++;
      tick();
      n_total++; if (out_data !== 32'hC || occupancy !== 2'd1)
         $display("FAIL bp_third got d=%h occ=%0d exp d=c occ=1", out_data, occupancy); else n_pass++;
      in_valid = 1'b0; tick();
      n_total++; if (occupancy !== 2'd0) $display("FAIL bp_drain_occ got %0d exp 0", occupancy); else n_pass++;
      n_total++; if (stall_cnt !== 16'd2) $display("FAIL bp_stall_final got %0d exp 2", stall_cnt); else n_pass++;
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b1; in_valid = 1'b1;
      in_data = 32'h11; tick();
      in_data = 32'h22; tick();
      n_total++; if (out_data !== 32'h22 || occupancy !== 2'd1)
         $display("FAIL sim_one_a got d=%h occ=%0d exp d=22 occ=1", out_data, occupancy); else n_pass++;
      in_data = 32'h33; tick();
      n_total++; if (out_data !== 32'h33 || occupancy !== 2'd1)
         $display("FAIL sim_one_b got d=%h occ=%0d exp d=33 occ=1", out_data, occupancy); else n_pass++;
      out_ready = 1'b0; in_data = 32'h44; tick();
      n_total++; if (occupancy !== 2'd2 || out_data !== 32'h33)
         $display("FAIL sim_two got d=%h occ=%0d exp d=33 occ=2", out_data, occupancy); else n_pass++;
      out_ready = 1'b1; in_valid = 1'b0; tick();
      n_total++; if (occupancy !== 2'd1 || out_data !== 32'h44)
         $display("FAIL sim_skid_pop got d=%h occ=%0d exp d=44 occ=1", out_data, occupancy); else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL sim_drain got %b exp 0", out_valid); else n_pass++;
      n_total++; if (stall_cnt !== 16'd3) $display("FAIL sim_stall got %0d exp 3", stall_cnt); else n_pass++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 32'h55; tick();
      in_data = 32'h66; tick();
      n_total++; if (occupancy !== 2'd2) $display("FAIL fl_fill got %0d exp 2", occupancy); else n_pass++;
      flush = 1'b1; in_data = 32'h77; tick();
      flush = 1'b0; in_valid = 1'b0;
      n_total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL fl_empty got occ=%0d v=%b r=%b exp occ=0 v=0 r=1", occupancy, out_valid, in_ready); else n_pass++;
      n_total++; if (stall_cnt !== 16'd5) $display("FAIL fl_stall got %0d exp 5", stall_cnt); else n_pass++;
      tick();
      n_total++; if (stall_cnt !== 16'd5 || occupancy !== 2'd0)
         $display("FAIL fl_idle got stall=%0d occ=%0d exp stall=5 occ=0", stall_cnt, occupancy); else n_pass++;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h88; tick();
      in_valid = 1'b0;
      n_total++; if (out_data !== 32'h88 || occupancy !== 2'd1)
         $display("FAIL fl_next got d=%h occ=%0d exp d=88 occ=1", out_data, occupancy); else n_pass++;
      tick();
      n_total++; if (occupancy !== 2'd0) $display("FAIL fl_drain got %0d exp 0", occupancy); else n_pass++;
   endtask

   task automatic test_reset_midtransfer();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h99; tick();
      out_ready = 1'b1; in_data = 32'hAA; rst = 1'b1; tick();
      rst = 1'b0; in_valid = 1'b0;
      n_total++; if (occupancy !== 2'd0 || out_data !== RV || stall_cnt !== 16'd0)
         $display("FAIL rst_mid got occ=%0d d=%h stall=%0d exp occ=0 d=%h stall=0",
                  occupancy, out_data, stall_cnt, RV); else n_pass++;
   endtask

   task automatic test_saturation();
      s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0; s_flush = 1'b0;
      tick();
      s_rst = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h3C; tick();
      s_in_valid = 1'b0;
      repeat (10) tick();
      n_total++; if (s_stall_cnt !== 4'd10) $display("FAIL sat_mid got %0d exp 10", s_stall_cnt); else n_pass++;
      repeat (10) tick();
      n_total++; if (s_stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d exp 15", s_stall_cnt); else n_pass++;
      n_total++; if (s_out_data !== 8'h3C || s_out_valid !== 1'b1)
         $display("FAIL sat_head got d=%h v=%b exp d=3c v=1", s_out_data, s_out_valid); else n_pass++;
      s_rst = 1'b1; tick();
      s_rst = 1'b0;
      n_total++; if (s_stall_cnt !== 4'd0) $display("FAIL sat_rst got %0d exp 0", s_stall_cnt); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_flush = 1'b0;
      #1;
      test_reset();
      test_streaming();
      test_backpressure();
      test_simultaneous();
      test_flush();
      test_reset_midtransfer();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register for the 5-stage CPU, replacing fixed-width enable registers between stages. It holds WIDTH bits of stage payload behind a valid/ready handshake, with a one-entry skid buffer so upstream `in_ready` is a registered signal. It also supports a synchronous flush for branch/hazard squashing and a saturating stall-cycle counter for performance monitoring.

## Interface
- WIDTH, 32, payload width in bits (>=1)
- RESET_VAL, 0, value loaded into both data registers on reset (WIDTH bits)
- CNT_W, 16, width of the stall counter (>=2)

- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream payload valid
- in_ready  output  1  buffer can accept; registered
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  head payload; driven directly from main register
- flush  input  1  discard all held entries (synchronous)
- occupancy  output  2  entries held: 0, 1 or 2
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main register (head) and skid register. States: EMPTY (0 entries), ONE (main full), TWO (main+skid full). occupancy encodes the state.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = (state != EMPTY); in_ready = (state != TWO), taken from the state register, never combinationally from out_ready.
- EMPTY: in_fire -> main<=in_data, go to ONE.
- ONE: in_fire & out_fire -> main<=in_data, stay in ONE. in_fire only -> skid<=in_data, go to TWO. out_fire only -> go to EMPTY. Neither -> hold.
- TWO: in_ready=0. out_fire -> main<=skid, go to ONE. Otherwise hold.
- Order is strictly FIFO. No payload is dropped or duplicated except on flush.
- Data registers load only on the transfers listed above. Otherwise they hold, including their stale contents while EMPTY.
- flush=1: next state EMPTY regardless of in_valid/out_ready. An input transfer in the same cycle is discarded. Data registers are not cleared.
- stall_cnt: +1 on each cycle with out_valid & !out_ready, saturating at 2^CNT_W-1. Flush does not clear it; only rst does.
- Priority: rst > flush > normal handshake.

## Timing
- Reset values: state EMPTY, out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL, skid=RESET_VAL, stall_cnt=0.
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N, provided the buffer was EMPTY or was draining.
- Throughput: one transfer per cycle sustained when out_ready=1.
- in_ready falls the cycle after the second entry is captured. Upstream sees at most one cycle of delayed backpressure, which is absorbed by the skid register.
- A stall cycle counts even on the cycle flush is asserted, because the count uses the pre-edge out_valid.
- rst asserted mid-transfer wins: all handshake outcomes that cycle are ignored.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 and in_data=0xDEADBEEF -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL, stall_cnt=0.
- Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after accept; in_ready stays 1; stall_cnt=0.
- Backpressure: out_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, occupancy=2, in_ready=0, 0xC held upstream. Then raise out_ready -> output sequence is 0xA, 0xB, 0xC with no loss; stall_cnt equals the number of stalled cycles.
- Simultaneous in/out in ONE: occupancy stays 1 and main updates each cycle. Then in_fire with no out_fire -> TWO. Then out_fire with no in_fire -> ONE, with out_data=former skid value.
- Flush: fill to TWO, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, the flush-cycle input is absent from the output stream; stall_cnt is unchanged apart from the flush cycle itself.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; rst -> 0.
